// File: rtl/mips_mc_datapath_regs.sv
// Multicycle MIPS datapath register stage: PC, IR, MDR, A, B, ALU_Out,
// next-PC and memory-address selection, instruction field decode.
module mips_mc_datapath_regs #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PC_Write,
    input  logic             Branch,
    input  logic             PC_Src,
    input  logic             PC_J,
    input  logic             IR_Write,
    input  logic             IorD,
    input  logic             Zero,
    input  logic [WIDTH-1:0] ALU_Result,
    input  logic [WIDTH-1:0] Mem_RD,
    input  logic [WIDTH-1:0] Reg_RD1,
    input  logic [WIDTH-1:0] Reg_RD2,
    output logic [WIDTH-1:0] Mem_Addr,
    output logic [WIDTH-1:0] Mem_WD,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] Instr,
    output logic [5:0]       Op,
    output logic [5:0]       Funct,
    output logic [4:0]       Rs,
    output logic [4:0]       Rt,
    output logic [4:0]       Rd,
    output logic [15:0]      Imm,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALU_Out,
    output logic [31:0]      Instr_Count,
    output logic             PC_Misaligned
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] mdr_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] alu_out_q;
    logic [31:0]      instr_count_q;
    logic             pc_misaligned_q;

    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] pc_next;
    logic             pc_en;

    // Jump target is formed from the pre-edge PC and IR.
    assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pc_next = jump_target;
        if (PC_J) begin
            pc_next = PC_Src ? alu_out_q : ALU_Result;
        end
    end

    assign pc_en = PC_Write | (Branch & Zero);

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            ir_q            <= '0;
            mdr_q           <= '0;
            a_q             <= '0;
            b_q             <= '0;
            alu_out_q       <= '0;
            instr_count_q   <= '0;
            pc_misaligned_q <= 1'b0;
        end else begin
            mdr_q     <= Mem_RD;
            a_q       <= Reg_RD1;
            b_q       <= Reg_RD2;
            alu_out_q <= ALU_Result;
            if (pc_en) begin
                pc_q <= pc_next;
                // Sticky until reset; the misaligned value still loads.
                if (pc_next[1:0] != 2'b00) begin
                    pc_misaligned_q <= 1'b1;
                end
            end
            if (IR_Write) begin
                ir_q          <= Mem_RD;
                instr_count_q <= instr_count_q + 32'd1;
            end
        end
    end

    assign Mem_Addr      = IorD ? alu_out_q : pc_q;
    assign Mem_WD        = b_q;
    assign PC            = pc_q;
    assign Instr         = ir_q;
    assign Op            = ir_q[31:26];
    assign Rs            = ir_q[25:21];
    assign Rt            = ir_q[20:16];
    assign Rd            = ir_q[15:11];
    assign Imm           = ir_q[15:0];
    assign Funct         = ir_q[5:0];
    assign MDR           = mdr_q;
    assign A             = a_q;
    assign B             = b_q;
    assign ALU_Out       = alu_out_q;
    assign Instr_Count   = instr_count_q;
    assign PC_Misaligned = pc_misaligned_q;

endmodule

// File: tb/tb_mips_mc_datapath_regs.sv
// Self-checking bench: per-cycle comparison against a behavioural model,
// plus directed vectors with literal expectations.
module tb_mips_mc_datapath_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_Write, Branch, PC_Src, PC_J, IR_Write, IorD, Zero;
    logic [31:0] ALU_Result, Mem_RD, Reg_RD1, Reg_RD2;
    logic [31:0] Mem_Addr, Mem_WD, PC, Instr, MDR, A, B, ALU_Out, Instr_Count;
    logic [5:0]  Op, Funct;
    logic [4:0]  Rs, Rt, Rd;
    logic [15:0] Imm;
    logic        PC_Misaligned;

    mips_mc_datapath_regs #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .PC_Write(PC_Write), .Branch(Branch), .PC_Src(PC_Src), .PC_J(PC_J),
        .IR_Write(IR_Write), .IorD(IorD), .Zero(Zero),
        .ALU_Result(ALU_Result), .Mem_RD(Mem_RD), .Reg_RD1(Reg_RD1), .Reg_RD2(Reg_RD2),
        .Mem_Addr(Mem_Addr), .Mem_WD(Mem_WD), .PC(PC), .Instr(Instr),
        .Op(Op), .Funct(Funct), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm),
        .MDR(MDR), .A(A), .B(B), .ALU_Out(ALU_Out),
        .Instr_Count(Instr_Count), .PC_Misaligned(PC_Misaligned)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model: what each register must hold after an edge.
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_alu_out, m_cnt;
    logic        m_mis;
    bit          model_valid = 0;

    always @(posedge clk) begin
        logic [31:0] target;
        if (rst) begin
            m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_a = 32'h0;
            m_b = 32'h0; m_alu_out = 32'h0; m_cnt = 32'h0; m_mis = 1'b0;
            model_valid = 1;
        end else begin
            if (!PC_J)       target = {m_pc[31:28], m_ir[25:0], 2'b00};
            else if (PC_Src) target = m_alu_out;
            else             target = ALU_Result;
            if (PC_Write || (Branch && Zero)) begin
                m_pc = target;
                if (target % 4 != 0) m_mis = 1'b1;
            end
            if (IR_Write) begin
                m_ir  = Mem_RD;
                m_cnt = m_cnt + 1;
            end
            m_mdr = Mem_RD; m_a = Reg_RD1; m_b = Reg_RD2; m_alu_out = ALU_Result;
        end
    end

    // Compare process: one sample per cycle, 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (model_valid) begin
            check("m_pc",       PC,                      m_pc);
            check("m_instr",    Instr,                   m_ir);
            check("m_op",       {26'd0, Op},             {26'd0, m_ir[31:26]});
            check("m_funct",    {26'd0, Funct},          {26'd0, m_ir[5:0]});
            check("m_rs",       {27'd0, Rs},             {27'd0, m_ir[25:21]});
            check("m_rt",       {27'd0, Rt},             {27'd0, m_ir[20:16]});
            check("m_rd",       {27'd0, Rd},             {27'd0, m_ir[15:11]});
            check("m_imm",      {16'd0, Imm},            {16'd0, m_ir[15:0]});
            check("m_mdr",      MDR,                     m_mdr);
            check("m_a",        A,                       m_a);
            check("m_b",        B,                       m_b);
            check("m_mem_wd",   Mem_WD,                  m_b);
            check("m_alu_out",  ALU_Out,                 m_alu_out);
            check("m_count",    Instr_Count,             m_cnt);
            check("m_misalign", {31'd0, PC_Misaligned},  {31'd0, m_mis});
            check("m_mem_addr", Mem_Addr,                IorD ? m_alu_out : m_pc);
        end
    end

    // Inputs change 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        rst = 0; PC_Write = 0; Branch = 0; PC_Src = 0; PC_J = 1;
        IR_Write = 0; IorD = 0; Zero = 0;
    endtask

    initial begin
        rst = 1; PC_Write = 1; Branch = 1; PC_Src = 1; PC_J = 1;
        IR_Write = 1; IorD = 0; Zero = 1;
        ALU_Result = $urandom; Mem_RD = $urandom; Reg_RD1 = $urandom; Reg_RD2 = $urandom;
        tick();

        // Reset with all enables high
        idle();
        check("rst_pc", PC, 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_mdr", MDR, 32'h0);
        check("rst_a", A, 32'h0);
        check("rst_b", B, 32'h0);
        check("rst_alu_out", ALU_Out, 32'h0);
        check("rst_count", Instr_Count, 32'h0);
        check("rst_misalign", {31'd0, PC_Misaligned}, 32'h0);
        check("rst_mem_addr", Mem_Addr, 32'h0);

        // Fetch
        Mem_RD = 32'h2009_000A; ALU_Result = 32'h4;
        IR_Write = 1; PC_Write = 1; PC_J = 1; PC_Src = 0;
        tick();
        idle();
        check("fetch_pc", PC, 32'h4);
        check("fetch_instr", Instr, 32'h2009_000A);
        check("fetch_op", {26'd0, Op}, 32'h08);
        check("fetch_rt", {27'd0, Rt}, 32'h9);
        check("fetch_imm", {16'd0, Imm}, 32'h000A);
        check("fetch_count", Instr_Count, 32'h1);

        // Branch: preload ALU_Out, then not taken, then taken
        ALU_Result = 32'h40;
        tick();
        Branch = 1; PC_Src = 1; PC_J = 1; Zero = 0;
        tick();
        check("br_nt_pc", PC, 32'h4);
        Zero = 1;
        tick();
        check("br_t_pc", PC, 32'h40);
        PC_Write = 1;
        ALU_Result = 32'h80;
        tick();
        idle();
        check("br_and_write_pc", PC, 32'h40);
        check("br_count_unchanged", Instr_Count, 32'h1);

        // Jump setup: PC=0x1000_0004, IR=0x0810_0040
        PC_Write = 1; PC_J = 1; PC_Src = 0; ALU_Result = 32'h1000_0004;
        IR_Write = 1; Mem_RD = 32'h0810_0040;
        tick();
        idle();
        PC_Write = 1; PC_J = 0;
        tick();
        idle();
        check("jump_pc", PC, 32'h1040_0100);

        // Address mux and store data
        ALU_Result = 32'h2000;
        tick();
        IorD = 1;
        #1;
        check("iord_mem_addr", Mem_Addr, 32'h2000);
        IorD = 0;
        #1;
        check("pc_mem_addr", Mem_Addr, 32'h1040_0100);
        Reg_RD2 = 32'hDEAD_BEEF; Mem_RD = 32'h1234_5678; Reg_RD1 = 32'hA5A5_0001;
        tick();
        check("mem_wd", Mem_WD, 32'hDEAD_BEEF);
        check("mdr", MDR, 32'h1234_5678);
        check("a_reg", A, 32'hA5A5_0001);

        // Misaligned PC, sticky flag
        PC_Write = 1; PC_J = 1; PC_Src = 0; ALU_Result = 32'h6;
        tick();
        check("mis_pc", PC, 32'h6);
        check("mis_flag", {31'd0, PC_Misaligned}, 32'h1);
        ALU_Result = 32'h100;
        tick();
        idle();
        check("mis_sticky_pc", PC, 32'h100);
        check("mis_sticky", {31'd0, PC_Misaligned}, 32'h1);

        // Instruction counter wrap
        force dut.instr_count_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_q;
        IR_Write = 1; Mem_RD = 32'h0000_0020;
        tick();
        idle();
        check("count_wrap", Instr_Count, 32'h0);
        check("wrap_funct", {26'd0, Funct}, 32'h20);

        // Reset mid-instruction with every enable active
        rst = 1; PC_Write = 1; Branch = 1; Zero = 1; IR_Write = 1;
        Mem_RD = 32'hFFFF_FFFF; ALU_Result = 32'h3;
        tick();
        idle();
        check("rst2_pc", PC, 32'h0);
        check("rst2_instr", Instr, 32'h0);
        check("rst2_misalign", {31'd0, PC_Misaligned}, 32'h0);
        check("rst2_count", Instr_Count, 32'h0);

        // Mixed random traffic, checked by the model only
        for (int i = 0; i < 40; i++) begin
            PC_Write = 1'($urandom); Branch = 1'($urandom); PC_Src = 1'($urandom);
            PC_J = 1'($urandom); IR_Write = 1'($urandom); IorD = 1'($urandom);
            Zero = 1'($urandom);
            ALU_Result = $urandom; Mem_RD = $urandom; Reg_RD1 = $urandom; Reg_RD2 = $urandom;
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
